// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: handshake and serial-line bundle for uart_tx_frame.
// Signals: i_p_data/i_data_valid/i_par_en/i_par_typ are driven by the master (system side);
// o_tx_out/o_busy are driven by the slave (the transmitter).
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_p_data;
    logic                  i_data_valid;
    logic                  i_par_en;
    logic                  i_par_typ;
    logic                  o_tx_out;
    logic                  o_busy;
    modport master (output i_p_data, i_data_valid, i_par_en, i_par_typ, input o_tx_out, o_busy);
    modport slave  (input i_p_data, i_data_valid, i_par_en, i_par_typ, output o_tx_out, o_busy);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, one i_clk per bit: start, data LSB first, optional parity, one stop.
// Ports: i_clk bit-rate clock; i_rst synchronous active-high reset;
//        bus (slave): i_p_data, i_data_valid, i_par_en, i_par_typ in; o_tx_out (idle high), o_busy out.
// Macro UART_TX_HOLD_EN adds a one-entry hold register so a request arriving mid-frame is
// sent right after the current stop bit with no idle bit.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input logic            i_clk,
    input logic            i_rst,
    uart_tx_frame_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                r_state, w_state;
    logic [DATA_WIDTH-1:0] r_data, w_data;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic                  r_par_en, w_par_en, r_par_typ, w_par_typ;
    logic                  r_tx, w_tx, r_busy, w_busy;
`ifdef UART_TX_HOLD_EN
    logic [DATA_WIDTH-1:0] r_hold_data, w_hold_data;
    logic                  r_hold_v, w_hold_v, r_hold_pe, w_hold_pe, r_hold_pt, w_hold_pt;
`endif
    assign bus.o_tx_out = r_tx;
    assign bus.o_busy   = r_busy;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_cnt     <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_HOLD_EN
            r_hold_v    <= 1'b0;
            r_hold_data <= '0;
            r_hold_pe   <= 1'b0;
            r_hold_pt   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_data    <= w_data;
            r_cnt     <= w_cnt;
            r_par_en  <= w_par_en;
            r_par_typ <= w_par_typ;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
`ifdef UART_TX_HOLD_EN
            r_hold_v    <= w_hold_v;
            r_hold_data <= w_hold_data;
            r_hold_pe   <= w_hold_pe;
            r_hold_pt   <= w_hold_pt;
`endif
        end
    end
    always_comb begin
        w_state   = r_state;
        w_data    = r_data;
        w_cnt     = r_cnt;
        w_par_en  = r_par_en;
        w_par_typ = r_par_typ;
`ifdef UART_TX_HOLD_EN
        w_hold_v    = r_hold_v;
        w_hold_data = r_hold_data;
        w_hold_pe   = r_hold_pe;
        w_hold_pt   = r_hold_pt;
        if (r_state != IDLE && !r_hold_v && bus.i_data_valid) begin
            w_hold_v    = 1'b1;
            w_hold_data = bus.i_p_data;
            w_hold_pe   = bus.i_par_en;
            w_hold_pt   = bus.i_par_typ;
        end
`endif
        case (r_state)
            IDLE: if (bus.i_data_valid) begin
                w_state   = START;
                w_data    = bus.i_p_data;
                w_par_en  = bus.i_par_en;
                w_par_typ = bus.i_par_typ;
            end
            START: begin
                w_state = DATA;
                w_cnt   = '0;
            end
            DATA: if (r_cnt == CW'(DATA_WIDTH - 1)) w_state = r_par_en ? PARITY : STOP;
                  else w_cnt = r_cnt + 1'b1;
            PARITY: w_state = STOP;
`ifdef UART_TX_HOLD_EN
            // A request captured on this very edge also chains, so the hold is checked post-capture.
            STOP: if (w_hold_v) begin
                w_state   = START;
                w_data    = w_hold_data;
                w_par_en  = w_hold_pe;
                w_par_typ = w_hold_pt;
                w_hold_v  = 1'b0;
            end else w_state = IDLE;
`else
            STOP: w_state = IDLE;
`endif
            default: w_state = IDLE;
        endcase
        // Line and busy are decoded from the next state so both leave straight from flops.
        w_tx = (w_state == START)  ? 1'b0 :
               (w_state == DATA)   ? w_data[w_cnt] :
               (w_state == PARITY) ? (^w_data) ^ w_par_typ : 1'b1;
`ifdef UART_TX_HOLD_EN
        w_busy = (w_state != IDLE) && w_hold_v;
`else
        w_busy = (w_state != IDLE);
`endif
    end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter that consumes the divided clock produced by the configurable clock divider.
- One i_clk cycle equals one bit period.
- Accepts a parallel byte via a valid/busy handshake. Emits start bit, data bits LSB first, optional parity bit and one stop bit on o_tx_out.
- Sits between the system-side register/FIFO read logic and the serial pad.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported range 5..9)

Ports:
i_clk  input  1  bit-rate clock (driven by divided clock output); all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_p_data  input  DATA_WIDTH  parallel data to transmit
i_data_valid  input  1  request to transmit i_p_data
i_par_en  input  1  1 = append parity bit
i_par_typ  input  1  0 = even parity, 1 = odd parity
o_tx_out  output  1  serial line, idle high
o_busy  output  1  1 = new request will not be accepted this cycle

Behaviour:
- Interface timing: one clock, i_clk. Reset is synchronous and active-high: i_rst sampled on the rising edge of i_clk.
- Reset values: o_tx_out = 1, o_busy = 0, FSM = IDLE, bit counter = 0, shift/parity registers = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx_out = 1, o_busy = 0.
  - On an edge with i_data_valid = 1: latch i_p_data, i_par_en and i_par_typ into internal registers; go to START.
- START: o_tx_out = 0, o_busy = 1, one cycle; then DATA with bit counter = 0.
- DATA:
  - o_tx_out = latched data bit [counter], LSB first; counter increments each cycle.
  - After bit DATA_WIDTH-1: go to PARITY if latched par_en = 1, else STOP.
- PARITY:
  - o_tx_out = XOR of latched data when par_typ = 0 (even).
  - o_tx_out = XNOR of latched data when par_typ = 1 (odd).
  - One cycle, then STOP.
- STOP: o_tx_out = 1, o_busy = 1, one cycle; then IDLE.
- Frame length: DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without.
- Latency: start bit appears on o_tx_out in the cycle immediately after the accepting edge.
- o_busy: high from the cycle after acceptance through the STOP cycle inclusive.
- Held i_data_valid: minimum one IDLE bit (line high) between consecutive frames.
- i_data_valid while o_busy = 1: ignored; data is dropped, not queued.
- Config changes mid-frame: i_p_data, i_par_en and i_par_typ changes have no effect on the frame in flight; only values latched at acceptance are used.
- Reset mid-frame:
  - Next cycle IDLE, o_tx_out = 1, o_busy = 0.
  - Partial frame is aborted and no stop bit is appended.
  - i_data_valid coincident with i_rst is ignored.
- Bit counter width: clog2(DATA_WIDTH); must not wrap within a frame.

Optional Feature:
Macro UART_TX_HOLD_EN.
- Defined: one-entry hold register (data + par_en + par_typ) is added.
  - o_busy = 1 only when FSM is not IDLE and the hold register is full.
  - A request accepted while FSM is active is stored in the hold register.
  - When STOP completes with the hold register full, FSM goes directly to START the next cycle with the held values: no idle bit, hold cleared.
  - A request accepted in IDLE behaves exactly as without the macro.
  - Reset clears the hold register.
- Undefined: no hold register; behaviour exactly as above.

Test Plan:
- Even parity: reset, i_par_en=1, i_par_typ=0, valid with i_p_data=0xA5.
  - o_tx_out = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; o_busy high for exactly those 11 cycles; then line stays 1.
- Odd parity: same as above with i_par_typ=1 -> parity bit (cycle 10) = 1; all other bits identical.
- No parity: i_par_en=0, i_p_data=0x0F -> 0,1,1,1,1,0,0,0,0,1 over 10 cycles, then idle.
- Request while busy: i_data_valid pulsed with 0x3C during the DATA state of a 0xA5 frame -> 0xA5 frame unchanged; no second frame sent.
  - With UART_TX_HOLD_EN: 0x3C frame starts in the cycle immediately after the 0xA5 stop bit.
- Reset mid-frame: i_rst asserted for 1 cycle during DATA bit 3 -> next cycle o_tx_out=1, o_busy=0.
  - A new valid 0x55 afterwards produces a complete, correct frame.
- Back-to-back with i_data_valid held high and DATA 0x55 then 0xAA:
  - Without macro: exactly one idle-high cycle between the frames.
  - With UART_TX_HOLD_EN: zero idle cycles between the frames.
